// File: rtl/mxint_dequant_serializer.sv
// Widens one MXINT block (shared exponent + BLOCK_SIZE signed mantissas) into
// signed fixed-point words and streams them out one per cycle with saturation.
module mxint_dequant_serializer #(
    parameter int BLOCK_SIZE = 4,
    parameter int MAN_WIDTH  = 8,
    parameter int EXP_WIDTH  = 8,
    parameter int EXP_BIAS   = 127,
    parameter int OUT_WIDTH  = 16,
    parameter int OUT_FRAC   = 4
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            in_valid,
    output logic                            in_ready,
    input  logic [EXP_WIDTH-1:0]            in_exp,
    input  logic [BLOCK_SIZE*MAN_WIDTH-1:0] in_man,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [OUT_WIDTH-1:0]            out_data,
    output logic                            out_last,
    output logic                            out_sat
);
    localparam int IW = (BLOCK_SIZE > 1) ? $clog2(BLOCK_SIZE) : 1;
    localparam int WW = MAN_WIDTH + OUT_WIDTH + 1;
    localparam logic [IW-1:0] LAST = IW'(BLOCK_SIZE - 1);
    localparam logic signed [WW-1:0] MAXV = {{(MAN_WIDTH+2){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
    localparam logic signed [WW-1:0] MINV = {{(MAN_WIDTH+2){1'b1}}, {(OUT_WIDTH-1){1'b0}}};

    typedef enum logic {IDLE, EMIT} state_t;

    state_t                               state, state_n;
    logic [IW-1:0]                        idx, idx_n;
    logic                                 load;
    logic [EXP_WIDTH-1:0]                 hold_exp;
    logic [BLOCK_SIZE-1:0][MAN_WIDTH-1:0] hold_man;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            idx   <= '0;
        end else begin
            state <= state_n;
            idx   <= idx_n;
        end
    end

    always_ff @(posedge clk) begin
        if (load) begin
            hold_exp <= in_exp;
            hold_man <= in_man;
        end
    end

    always_comb begin
        state_n   = state;
        idx_n     = idx;
        load      = 1'b0;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    load    = 1'b1;
                    idx_n   = '0;
                    state_n = EMIT;
                end
            end
            EMIT: begin
                out_valid = 1'b1;
                // Refill is only possible on the cycle the final word leaves.
                in_ready  = (idx == LAST) && out_ready;
                if (out_ready) begin
                    if (idx != LAST) begin
                        idx_n = idx + 1'b1;
                    end else if (in_valid) begin
                        load  = 1'b1;
                        idx_n = '0;
                    end else begin
                        idx_n   = '0;
                        state_n = IDLE;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    int                          sh, lsh, rsh;
    logic signed [MAN_WIDTH-1:0] m;
    logic signed [WW-1:0]        mext, wide;
    logic [OUT_WIDTH-1:0]        data;
    logic                        sat;

    // Shift amounts are capped: any nonzero mantissa shifted left by OUT_WIDTH
    // already saturates, and right shifts by MAN_WIDTH leave only the sign.
    always_comb begin
        m    = hold_man[idx];
        mext = {{(WW-MAN_WIDTH){m[MAN_WIDTH-1]}}, m};
        sh   = int'(hold_exp) - EXP_BIAS + OUT_FRAC;
        lsh  = (sh > OUT_WIDTH) ? OUT_WIDTH : sh;
        rsh  = (-sh > MAN_WIDTH) ? MAN_WIDTH : -sh;
        wide = (sh >= 0) ? (mext <<< lsh) : (mext >>> rsh);
        sat  = 1'b0;
        data = wide[OUT_WIDTH-1:0];
        if (wide > MAXV) begin
            data = MAXV[OUT_WIDTH-1:0];
            sat  = (sh >= 0);
        end else if (wide < MINV) begin
            data = MINV[OUT_WIDTH-1:0];
            sat  = (sh >= 0);
        end
    end

    assign out_data = (state == EMIT) ? data : '0;
    assign out_sat  = (state == EMIT) && sat;
    assign out_last = (state == EMIT) && (idx == LAST);

endmodule

// File: tb/tb_mxint_dequant_serializer.sv
// Directed + randomized checks of mxint_dequant_serializer against an
// arithmetic reference model of the dequantization rules.
module tb_mxint_dequant_serializer;
    localparam int BS = 4, MW = 8, EW = 8, BIAS = 127, OW = 16, OF = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic              in_valid;
    logic              in_ready;
    logic [EW-1:0]     in_exp;
    logic [BS*MW-1:0]  in_man;
    logic              out_valid;
    logic              out_ready;
    logic [OW-1:0]     out_data;
    logic              out_last;
    logic              out_sat;

    int vectors = 0;
    int errors  = 0;

    mxint_dequant_serializer #(
        .BLOCK_SIZE(BS), .MAN_WIDTH(MW), .EXP_WIDTH(EW),
        .EXP_BIAS(BIAS), .OUT_WIDTH(OW), .OUT_FRAC(OF)
    ) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_exp(in_exp), .in_man(in_man),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_last(out_last), .out_sat(out_sat)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, $signed(got), $signed(exp));
        end
    endtask

    // value = m * 2^sh, clamped on the left-shift side, floored on the right.
    function automatic void model(input int ex, input int m, output int v, output bit s);
        int     sh, rs, d, q;
        longint w;
        sh = ex - BIAS + OF;
        s  = 1'b0;
        v  = 0;
        if (sh >= 0) begin
            if (m == 0) v = 0;
            else if (sh >= 40) begin
                v = (m > 0) ? 32767 : -32768;
                s = 1'b1;
            end else begin
                w = longint'(m) * (longint'(1) << sh);
                if (w > 32767) begin v = 32767; s = 1'b1; end
                else if (w < -32768) begin v = -32768; s = 1'b1; end
                else v = int'(w);
            end
        end else begin
            rs = -sh;
            if (rs >= 30) v = (m < 0) ? -1 : 0;
            else begin
                d = 1 << rs;
                q = m / d;
                if (m < 0 && q * d != m) q = q - 1;
                v = q;
            end
        end
    endfunction

    task automatic drive_block(input int ex, input int man[4]);
        in_valid = 1'b1;
        in_exp   = EW'(ex);
        for (int i = 0; i < BS; i++) in_man[i*MW +: MW] = MW'(man[i]);
    endtask

    task automatic check_word(input int ex, input int m, input int e);
        int v; bit s;
        model(ex, m, v, s);
        chk("out_valid", 32'(out_valid), 1);
        chk("out_data", 32'($signed(out_data)), v);
        chk("out_sat", 32'(out_sat), 32'(s));
        chk("out_last", 32'(out_last), (e == BS-1) ? 1 : 0);
        chk("in_ready_emit", 32'(in_ready), (e == BS-1 && out_ready) ? 1 : 0);
    endtask

    // Accept one block from IDLE, then drain it with the given ready pattern.
    task automatic run_block(input int ex, input int man[4], input int stall_e,
                             input int stall_n, input bit rnd);
        int e, stalled, budget;
        drive_block(ex, man);
        out_ready = 1'b1;
        @(negedge clk);
        chk("idle_in_ready", 32'(in_ready), 1);
        chk("idle_out_valid", 32'(out_valid), 0);
        @(posedge clk); #1;
        in_valid = 1'b0;
        e = 0; stalled = 0; budget = 0;
        while (e < BS && budget < 200) begin
            if (rnd) out_ready = ($urandom % 3) != 0;
            else     out_ready = !(e == stall_e && stalled < stall_n);
            if (!out_ready) stalled++;
            @(negedge clk);
            check_word(ex, man[e], e);
            @(posedge clk); #1;
            if (out_ready) e++;
            budget++;
        end
        chk("block_drained", e, BS);
        out_ready = 1'b1;
        @(negedge clk);
        chk("end_out_valid", 32'(out_valid), 0);
        @(posedge clk); #1;
    endtask

    initial begin
        int rm[4];
        int rex;
        rst = 1'b1; in_valid = 1'b0; in_exp = '0; in_man = '0; out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        @(negedge clk);
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_in_ready", 32'(in_ready), 1);
        chk("rst_out_last", 32'(out_last), 0);
        chk("rst_out_sat", 32'(out_sat), 0);
        chk("rst_out_data", 32'(out_data), 0);
        @(posedge clk); #1;

        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("idle_valid", 32'(out_valid), 0);
            chk("idle_ready", 32'(in_ready), 1);
            @(posedge clk); #1;
        end

        run_block(127, '{1, -1, 127, -128}, -1, 0, 1'b0);
        run_block(131, '{127, -128, 0, 1}, -1, 0, 1'b0);
        run_block(132, '{127, -128, 0, 1}, -1, 0, 1'b0);
        run_block(255, '{0, 0, 0, 0}, -1, 0, 1'b0);
        run_block(255, '{1, -1, 0, 3}, -1, 0, 1'b0);
        run_block(121, '{7, -7, -1, 3}, -1, 0, 1'b0);
        run_block(0, '{5, -5, 0, -128}, -1, 0, 1'b0);
        run_block(127, '{1, -1, 127, -128}, 1, 3, 1'b0);
        run_block(130, '{3, -9, 100, -100}, 0, 3, 1'b0);

        // Back-to-back: second block offered during the whole first block.
        begin
            int ma[4] = '{1, 2, 3, 4};
            int mb[4] = '{-5, 6, -7, 8};
            drive_block(128, ma);
            out_ready = 1'b1;
            @(negedge clk);
            chk("b2b_accept", 32'(in_ready), 1);
            @(posedge clk); #1;
            drive_block(126, mb);
            for (int k = 0; k < 2*BS; k++) begin
                @(negedge clk);
                check_word((k < BS) ? 128 : 126, (k < BS) ? ma[k] : mb[k-BS], k % BS);
                @(posedge clk); #1;
                if (k == BS-1) in_valid = 1'b0;
            end
            @(negedge clk);
            chk("b2b_end_valid", 32'(out_valid), 0);
            @(posedge clk); #1;
        end

        // Reset right after element 1 is taken.
        begin
            int mc[4] = '{10, 20, 30, 40};
            drive_block(127, mc);
            out_ready = 1'b1;
            @(posedge clk); #1;
            in_valid = 1'b0;
            for (int k = 0; k < 2; k++) begin
                @(negedge clk);
                check_word(127, mc[k], k);
                @(posedge clk); #1;
            end
            rst = 1'b1;
            @(posedge clk); #1;
            rst = 1'b0;
            @(negedge clk);
            chk("midrst_valid", 32'(out_valid), 0);
            chk("midrst_ready", 32'(in_ready), 1);
            chk("midrst_last", 32'(out_last), 0);
            @(posedge clk); #1;
            run_block(129, '{-3, 4, -5, 6}, -1, 0, 1'b0);
        end

        for (int t = 0; t < 40; t++) begin
            rex = (($urandom % 4) == 0) ? int'($urandom % 256) : 110 + int'($urandom % 31);
            for (int i = 0; i < BS; i++) rm[i] = int'($urandom % 256) - 128;
            run_block(rex, rm, -1, 0, 1'b1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule

// File: doc/mxint_dequant_serializer.md
Name: mxint_dequant_serializer

Overview:
- Converts one MXINT block per handshake (a shared exponent plus BLOCK_SIZE signed mantissas) into BLOCK_SIZE signed fixed-point words.
- Emits the words one per cycle over a valid/ready stream, with a last flag on the final word.
- Sits at the output of the MXINT datapath, where blocks are widened back to plain fixed point for downstream accumulators.
- Saturates any word that overflows OUT_WIDTH to the signed range, and flags it.

Parameters:
BLOCK_SIZE, 4, mantissas per block (>=2)
MAN_WIDTH, 8, signed mantissa width
EXP_WIDTH, 8, unsigned shared-exponent width
EXP_BIAS, 127, exponent bias
OUT_WIDTH, 16, signed output width
OUT_FRAC, 4, fractional bits of the output fixed-point format

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
in_valid  in  1  block valid
in_ready  out  1  block accepted when in_valid && in_ready
in_exp  in  EXP_WIDTH  shared exponent, unsigned
in_man  in  BLOCK_SIZE*MAN_WIDTH  mantissas; element i at [i*MAN_WIDTH +: MAN_WIDTH]
out_valid  out  1  word valid
out_ready  in  1  downstream accepts
out_data  out  OUT_WIDTH  signed fixed-point word
out_last  out  1  high on element BLOCK_SIZE-1
out_sat  out  1  out_data was saturated

Behaviour:
- Clock and reset: single clock clk; rst is synchronous and active-high, sampled on the rising edge.
- Reset values: state IDLE, idx=0, out_valid=0, in_ready=1, out_last=0, out_sat=0, out_data=0.
- States:
  - IDLE: in_ready=1, out_valid=0.
  - EMIT: out_valid=1; outputs element idx of the held block.
- Accept and start: a handshake in IDLE captures in_exp and in_man into holding registers, sets idx=0 and moves to EMIT.
  - First word is valid the cycle after acceptance.
  - No combinational path from any in_* input to any out_* output.
- Word advance: in EMIT, an out handshake with idx<BLOCK_SIZE-1 increments idx.
- Block end and back-to-back: an out handshake with idx==BLOCK_SIZE-1:
  - with in_valid=1, captures the new block, sets idx=0 and stays in EMIT;
  - otherwise returns to IDLE.
- in_ready in EMIT: in_ready = (idx==BLOCK_SIZE-1) && out_ready. Consecutive blocks therefore stream with no bubble: one word per cycle.
- Backpressure: while out_valid && !out_ready, out_data, out_last, out_sat and idx hold stable, and in_ready=0.
- Arithmetic, shift amount:
  - sh = in_exp - EXP_BIAS + OUT_FRAC, computed signed and wide enough for every exponent value (no wrap).
  - The ideal value is m * 2^sh, where m is the signed mantissa.
- Arithmetic, left shift (sh>=0):
  - Compute the left shift in a width that cannot overflow.
  - Clamp to the range [-2^(OUT_WIDTH-1), 2^(OUT_WIDTH-1)-1].
  - out_sat=1 when the clamp changed the value.
  - m=0 always gives 0 with out_sat=0, whatever the sh.
- Arithmetic, right shift (sh<0):
  - Arithmetic right shift by -sh, i.e. floor (round toward minus infinity).
  - When -sh >= MAN_WIDTH the result is 0 for m>=0 and -1 for m<0.
  - out_sat=0.
- Element order: element 0 is emitted first; out_last=1 only on element BLOCK_SIZE-1.
- Reset mid-block: the partially emitted block is discarded.
  - Next cycle: out_valid=0, in_ready=1, idx=0.
  - No word of the old block appears after reset.
- out_data and out_sat are don't-care when out_valid=0. out_last is 0 when out_valid=0.

Test Plan (defaults):
1. Basic conversion: exp=127 (sh=4), man={1,-1,127,-128}, out_ready=1 → words 16, -16, 2032, -2048 on four consecutive cycles starting 1 cycle after accept; out_last on the 4th only; out_sat=0 throughout.
2. Saturation boundary:
   - exp=131 (sh=8), man={127,-128,0,1} → 32512, -32768, 0, 256, out_sat=0.
   - exp=132 (sh=9), same man → 32767 (sat=1), -32768 (sat=1), 0 (sat=0), 512 (sat=0).
   - exp=255, man={0,0,0,0} → all 0, sat=0.
3. Right shift:
   - exp=121 (sh=-2), man={7,-7,-1,3} → 1, -2, -1, 0.
   - exp=0 (sh=-123), man={5,-5,0,-128} → 0, -1, 0, -1.
4. Backpressure and throughput:
   - out_ready low for 3 cycles while element 1 is presented → element 1 value, out_last=0, in_ready=0 held stable for 3 cycles, then the sequence resumes.
   - Two blocks offered back-to-back with out_ready=1 → 8 words in 8 consecutive cycles; in_ready=1 only on the cycle element 3 of block 1 is taken.
5. Reset mid-block: assert rst for 1 cycle right after element 1 is accepted → next cycle out_valid=0, in_ready=1. The next block then emits its element 0 first, with correct values.
6. Idle behaviour: in_valid=0 for 10 cycles after reset → out_valid stays 0 and in_ready stays 1. A block arriving with out_ready=0 → out_valid=1 with element 0 held until out_ready rises.
